// File: rtl/avalon_pio_in_irq.sv
// Avalon-MM read-only input PIO with synchronizer, per-bit edge capture
// (write-1-to-clear), interrupt mask and a registered interrupt output.
// Optional feature macro: PIO_IN_DEBOUNCE_EN adds a per-bit stable-cycle
// debounce filter between the synchronizer and the data/edge logic.
//
// Word address map:
//   0 data         RO  [WIDTH-1:0] filtered input value
//   1 capability   RO  [7:0] WIDTH, [9:8] EDGE_TYPE, [10] IRQ_MODE, [11] debounce
//   2 irqmask      RW  [WIDTH-1:0]
//   3 edgecapture  RW1C [WIDTH-1:0]
module avalon_pio_in_irq #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned IRQ_MODE        = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned ARM_W = 3;
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

`ifdef PIO_IN_DEBOUNCE_EN
    localparam logic DEBOUNCE_BUILT = 1'b1;
`else
    localparam logic DEBOUNCE_BUILT = 1'b0;
`endif

    localparam logic [31:0] CAPABILITY = {20'd0, DEBOUNCE_BUILT, 1'(IRQ_MODE),
                                          2'(EDGE_TYPE), 8'(WIDTH)};

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_val;
    logic [WIDTH-1:0]                  data_val;
    logic [WIDTH-1:0]                  prev_val;
    logic [WIDTH-1:0]                  edge_det;
    logic [WIDTH-1:0]                  irqmask;
    logic [WIDTH-1:0]                  edgecapture;
    logic [WIDTH-1:0]                  wr_clear;
    logic [ARM_W-1:0]                  arm_cnt;
    logic                              armed;
    logic                              wr_en;
    logic [31:0]                       rd_mux_c;
    logic                              irq_c;
    logic                              unused_bits;

    // Upper writedata bits beyond WIDTH carry no state.
    assign unused_bits = ^{writedata, 16'(DEBOUNCE_CYCLES)};

    // Multi-flop synchronizer for the asynchronous status inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1];

    // Arm counter: holds off edge capture until the synchronizer has filled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt <= '0;
        end else if (arm_cnt != ARM_DONE) begin
            arm_cnt <= arm_cnt + ARM_W'(1);
        end
    end

    assign armed = (arm_cnt == ARM_DONE);

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0][CNT_W-1:0] db_cnt;
    logic [WIDTH-1:0]            data_q;

    // Debounce: a bit follows sync_val only after DEBOUNCE_CYCLES stable cycles.
    // Before arming, data tracks sync directly so reset-time levels load quietly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            db_cnt <= '0;
        end else if (!armed) begin
            data_q <= sync_val;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (sync_val[i] != data_q[i]) begin
                    if (db_cnt[i] == CNT_LAST) begin
                        data_q[i] <= sync_val[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign data_val = data_q;
`else
    assign data_val = sync_val;
`endif

    // Previous data value for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_val <= '0;
        end else begin
`ifdef PIO_IN_DEBOUNCE_EN
            prev_val <= armed ? data_val : sync_val;
`else
            prev_val <= data_val;
`endif
        end
    end

    // Edge selection: rising, falling or any.
    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = data_val & ~prev_val;
            1:       edge_det = ~data_val & prev_val;
            default: edge_det = data_val ^ prev_val;
        endcase
    end

    assign wr_en    = chipselect & ~write_n;
    assign wr_clear = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

    // Edge capture: W1C clear, with a same-cycle set taking priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~wr_clear) | (armed ? edge_det : '0);
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (wr_en && (address == 2'd2)) begin
            irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Read mux from current (pre-update) register values.
    always_comb begin
        rd_mux_c = '0;
        case (address)
            2'd0:    rd_mux_c = 32'(data_val);
            2'd1:    rd_mux_c = CAPABILITY;
            2'd2:    rd_mux_c = 32'(irqmask);
            default: rd_mux_c = 32'(edgecapture);
        endcase
    end

    // Interrupt source: masked edge capture or masked live data.
    always_comb begin
        irq_c = 1'b0;
        if (IRQ_MODE == 1) begin
            irq_c = |(irqmask & edgecapture);
        end else begin
            irq_c = |(irqmask & data_val);
        end
    end

    // Registered bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_mux_c;
            irq      <= irq_c;
        end
    end

endmodule

// File: tb/tb_avalon_pio_in_irq.sv
// Bench for avalon_pio_in_irq: four instances with different edge/IRQ/sync
// settings share one stimulus; a reference model predicts readdata and irq
// for every cycle into a scoreboard that a negedge monitor drains.
`timescale 1ns/1ps
module tb_avalon_pio_in_irq;

    localparam int W     = 16;
    localparam int ND    = 4;
    localparam int DB    = 8;
    localparam int HMAX  = 8192;
    localparam int SS[ND] = '{2, 3, 4, 2};
    localparam int ET[ND] = '{0, 1, 2, 0};
    localparam int IM[ND] = '{1, 1, 1, 0};
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int DBG = 1;
`else
    localparam int DBG = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rdata [ND];
    logic          irqv  [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        avalon_pio_in_irq #(
            .WIDTH          (W),
            .SYNC_STAGES    (SS[g]),
            .EDGE_TYPE      (ET[g]),
            .IRQ_MODE       (IM[g]),
            .DEBOUNCE_CYCLES(DB)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .address   (address),
            .chipselect(chipselect),
            .write_n   (write_n),
            .writedata (writedata),
            .readdata  (rdata[g]),
            .in_port   (in_port),
            .irq       (irqv[g])
        );
    end

    typedef struct packed {
        logic [ND-1:0][31:0] rd;
        logic [ND-1:0]       irq;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [W-1:0]  cur_in;

    // Reference model state: input samples per edge and data value after each edge.
    int            m;
    logic [W-1:0]  samp [HMAX];
    logic [W-1:0]  dh   [ND][HMAX];
    logic [W-1:0]  ec   [ND];
    logic [W-1:0]  mask;
`ifdef PIO_IN_DEBOUNCE_EN
    int            cnt  [ND][W];
`endif

    // Synchronizer output after edge k: the input sampled SS edges earlier.
    function automatic logic [W-1:0] sync_at(input int d, input int k);
        int j;
        j = k - SS[d];
        return (j >= 0) ? samp[j] : '0;
    endfunction

    function automatic logic [W-1:0] edge_of(input int d, input logic [W-1:0] cur,
                                             input logic [W-1:0] prv);
        if (ET[d] == 0) return cur & ~prv;
        if (ET[d] == 1) return ~cur & prv;
        return cur ^ prv;
    endfunction

    function automatic logic [31:0] cap(input int d);
        return 32'(W) | (32'(ET[d]) << 8) | (32'(IM[d]) << 10) | (32'(DBG) << 11);
    endfunction

    // Model step at each rising edge; expected outputs appear after that edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m    = 0;
                mask = '0;
                for (int d = 0; d < ND; d++) begin
                    ec[d]    = '0;
                    dh[d][0] = '0;
`ifdef PIO_IN_DEBOUNCE_EN
                    for (int b = 0; b < W; b++) cnt[d][b] = 0;
`endif
                end
            end else begin
                exp_t         e;
                logic         wr;
                logic [W-1:0] cur, prv, set, clr, nd;
                m = m + 1;
                samp[m-1] = in_port;
                wr = chipselect && !write_n;
                e  = '0;
                for (int d = 0; d < ND; d++) begin
                    int first_cap;
                    cur = dh[d][m-1];
                    prv = (m >= 2) ? dh[d][m-2] : '0;
                    e.irq[d] = (IM[d] == 1) ? |(mask & ec[d]) : |(mask & cur);
                    case (address)
                        2'd0:    e.rd[d] = 32'(cur);
                        2'd1:    e.rd[d] = cap(d);
                        2'd2:    e.rd[d] = 32'(mask);
                        default: e.rd[d] = 32'(ec[d]);
                    endcase
                    first_cap = SS[d] + 2 + DBG;
                    set = (m >= first_cap) ? edge_of(d, cur, prv) : '0;
                    clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
                    ec[d] = (ec[d] & ~clr) | set;
`ifdef PIO_IN_DEBOUNCE_EN
                    nd = cur;
                    if (m <= SS[d] + 1) begin
                        nd = sync_at(d, m - 1);
                        for (int b = 0; b < W; b++) cnt[d][b] = 0;
                    end else begin
                        logic [W-1:0] s;
                        s = sync_at(d, m - 1);
                        for (int b = 0; b < W; b++) begin
                            if (s[b] != cur[b]) begin
                                if (cnt[d][b] == DB - 1) begin
                                    nd[b]     = s[b];
                                    cnt[d][b] = 0;
                                end else begin
                                    cnt[d][b] = cnt[d][b] + 1;
                                end
                            end else begin
                                cnt[d][b] = 0;
                            end
                        end
                    end
`else
                    nd = sync_at(d, m);
`endif
                    dh[d][m] = nd;
                end
                if (wr && address == 2'd2) mask = writedata[W-1:0];
                sb.push_back(e);
            end
        end
    end

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %08h, expected %08h at t=%0t",
                      name, d, act, exp, $time);
    endtask

    // Monitor: pops one prediction per presented output cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                sb.delete();
                for (int d = 0; d < ND; d++) begin
                    check("reset_readdata", d, rdata[d], 32'h0);
                    check("reset_irq", d, 32'(irqv[d]), 32'h0);
                end
            end else if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                for (int d = 0; d < ND; d++) begin
                    check($sformatf("readdata_a%0d", address), d, rdata[d], e.rd[d]);
                    check("irq", d, 32'(irqv[d]), 32'(e.irq[d]));
                end
                if (sb.size() != 0) begin
                    n_checks++;
                    $display("FAIL scoreboard_backlog: got %0d pending, expected 0", sb.size());
                end
            end
        end
    end

    task automatic drive(input logic [1:0] a, input logic we, input logic [31:0] wd);
        @(posedge clk);
        #2;
        address    = a;
        chipselect = we;
        write_n    = !we;
        writedata  = wd;
        in_port    = cur_in;
    endtask

    task automatic idle(input int n, input logic [1:0] a);
        repeat (n) drive(a, 1'b0, 32'($urandom));
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #2;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        in_port    = cur_in;
        repeat (n) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        cur_in     = 16'hFFFF;
        in_port    = cur_in;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Inputs high through reset: no capture, data reads back all ones.
        idle(10, 2'd3);
        idle(3, 2'd0);

        // Rising capture on bit 2 with mask bit 2.
        cur_in = '0;
        idle(8, 2'd0);
        drive(2'd2, 1'b1, 32'h0000_0004);
        cur_in[2] = 1'b1;
        idle(8, 2'd3);

        // Write-1-to-clear, then write 0 after a falling edge.
        drive(2'd3, 1'b1, 32'h0000_0004);
        idle(3, 2'd3);
        cur_in[2] = 1'b0;
        idle(8, 2'd3);
        drive(2'd3, 1'b1, 32'h0);
        idle(3, 2'd3);

        // Rising edge on bit 2 coincident with its clear on the 2-stage instance.
        drive(2'd3, 1'b1, 32'h0000_FFFF);
        idle(3, 2'd3);
        cur_in[2] = 1'b1;
        drive(2'd3, 1'b0, 32'h0);
        drive(2'd3, 1'b0, 32'h0);
        drive(2'd3, 1'b1, 32'h0000_0004);
        idle(5, 2'd3);

        // Level interrupt on bit 15, capability read.
        drive(2'd2, 1'b1, 32'h0000_8000);
        cur_in[15] = 1'b1;
        idle(8, 2'd1);
        cur_in[15] = 1'b0;
        idle(8, 2'd0);

        // Short and long pulses on bit 1.
        drive(2'd2, 1'b1, 32'h0000_FFFF);
        drive(2'd3, 1'b1, 32'hFFFF_FFFF);
        cur_in = '0;
        idle(12, 2'd0);
        cur_in[1] = 1'b1;
        idle(5, 2'd0);
        cur_in[1] = 1'b0;
        idle(15, 2'd3);
        cur_in[1] = 1'b1;
        idle(20, 2'd0);
        cur_in[1] = 1'b0;
        idle(15, 2'd3);

        // Reset mid-operation with inputs high.
        cur_in = 16'hFFFF;
        do_reset(2);
        idle(12, 2'd3);

        // Randomized traffic: sparse input toggles, random writes and reads.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
            cur_in = cur_in ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            for (int c = 0; c < int'($urandom_range(1, 12)); c++) begin
                if ($urandom_range(0, 3) == 0)
                    drive(2'($urandom_range(0, 3)), 1'b1, 32'($urandom));
                else
                    drive(2'($urandom_range(0, 3)), 1'b0, 32'($urandom));
            end
        end
        idle(4, 2'd3);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
